gnot16_chk: RTL and testbench

- Hardware response checker for the 16-bit inverter datapath (gnot16).
- Consumes stimulus/response pairs (a, y) over a valid/ready stream and verifies y == ~a per beat.
- Counts vectors and mismatches, and captures the first failing pair.
- Sits at the receiving end of a gnot16 stimulus source, so a self-checking bench or on-chip BIST needs no $monitor inspection.

---
 rtl/gnot16_chk_if.sv | 38 +++
 rtl/gnot16_chk.sv | 136 +++++++++++++
 tb/tb_gnot16_chk.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/gnot16_chk_if.sv
// Stream interface carrying (a, y) stimulus/response pairs into gnot16_chk.
// GNOT16_CHK_MASK_EN adds a per-beat compare mask.
interface gnot16_chk_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_y;
    logic             in_last;
`ifdef GNOT16_CHK_MASK_EN
    logic [WIDTH-1:0] in_mask;
`endif

    modport master (
        input  in_ready,
        output in_valid,
        output in_a,
        output in_y,
        output in_last
`ifdef GNOT16_CHK_MASK_EN
        ,
        output in_mask
`endif
    );

    modport slave (
        output in_ready,
        input  in_valid,
        input  in_a,
        input  in_y,
        input  in_last
`ifdef GNOT16_CHK_MASK_EN
        ,
        input  in_mask
`endif
    );
endinterface

// File: rtl/gnot16_chk.sv
// Response checker for gnot16: verifies y == ~a per accepted beat, counts vectors/errors.
// Define GNOT16_CHK_MASK_EN for masked compare plus a mismatching-bit counter.
module gnot16_chk #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    gnot16_chk_if.slave      bus,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
`ifdef GNOT16_CHK_MASK_EN
    output logic [CNT_W-1:0] bit_err_count,
`endif
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_y
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q;
    logic             ready_q, busy_q, done_q, pass_q;
    logic [CNT_W-1:0] vec_q, err_q, idx_q;
    logic [WIDTH-1:0] fa_q, fy_q;

    logic             accept, mismatch;
    logic [WIDTH-1:0] diff;
    logic [CNT_W-1:0] vec_inc, err_inc;

`ifdef GNOT16_CHK_MASK_EN
    logic [CNT_W-1:0] bits_q, bits_inc, pop;
    logic [CNT_W:0]   bits_sum;
`endif

    always_comb begin
        diff = bus.in_y ^ ~bus.in_a;
`ifdef GNOT16_CHK_MASK_EN
        diff = diff & bus.in_mask;
`endif
        mismatch = |diff;
        accept   = ready_q & bus.in_valid;
        vec_inc  = (vec_q == '1) ? vec_q : vec_q + CNT_W'(1);
        err_inc  = err_q;
        if (mismatch && (err_q != '1)) err_inc = err_q + CNT_W'(1);
    end

`ifdef GNOT16_CHK_MASK_EN
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (diff[i]) pop = pop + CNT_W'(1);
        end
        // One extra bit catches overflow so the sum saturates instead of wrapping.
        bits_sum = {1'b0, bits_q} + {1'b0, pop};
        bits_inc = bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            vec_q   <= '0;
            err_q   <= '0;
            idx_q   <= '0;
            fa_q    <= '0;
            fy_q    <= '0;
`ifdef GNOT16_CHK_MASK_EN
            bits_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        vec_q   <= '0;
                        err_q   <= '0;
                        idx_q   <= '0;
                        fa_q    <= '0;
                        fy_q    <= '0;
`ifdef GNOT16_CHK_MASK_EN
                        bits_q  <= '0;
`endif
                    end
                end
                StRun: begin
                    if (accept) begin
                        vec_q <= vec_inc;
                        err_q <= err_inc;
`ifdef GNOT16_CHK_MASK_EN
                        bits_q <= bits_inc;
`endif
                        // err_q is only zero before any error, so the capture happens once.
                        if (mismatch && (err_q == '0)) begin
                            idx_q <= vec_q;
                            fa_q  <= bus.in_a;
                            fy_q  <= bus.in_y;
                        end
                        if (bus.in_last) begin
                            state_q <= StDone;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_inc == '0);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign vec_count     = vec_q;
    assign err_count     = err_q;
    assign first_err_idx = idx_q;
    assign first_err_a   = fa_q;
    assign first_err_y   = fy_q;
`ifdef GNOT16_CHK_MASK_EN
    assign bit_err_count = bits_q;
`endif
endmodule

// File: tb/tb_gnot16_chk.sv
// Directed bench for gnot16_chk: a reference model pushes expected run results to a
// scoreboard queue, popped and compared when the checker raises done.
module tb_gnot16_chk;
    logic        clk = 1'b0;
    logic        rst, start;
    logic        busy, done, pass;
    logic [15:0] vec_count, err_count, first_err_idx, first_err_a, first_err_y;
    logic [15:0] bit_err_count;

    gnot16_chk_if #(.WIDTH(16)) bus ();

    gnot16_chk #(.WIDTH(16), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .vec_count     (vec_count),
        .err_count     (err_count),
`ifdef GNOT16_CHK_MASK_EN
        .bit_err_count (bit_err_count),
`endif
        .first_err_idx (first_err_idx),
        .first_err_a   (first_err_a),
        .first_err_y   (first_err_y)
    );

`ifndef GNOT16_CHK_MASK_EN
    assign bit_err_count = '0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] vec, err, idx, a, y, bits;
        logic        pass;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] m_vec, m_err, m_idx, m_a, m_y, m_bits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_vec = '0; m_err = '0; m_idx = '0; m_a = '0; m_y = '0; m_bits = '0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_clear();
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_ready", {31'd0, bus.in_ready}, 32'd1);
        check("start_done_clr", {31'd0, done}, 32'd0);
        check("start_vec_clr", {16'd0, vec_count}, 32'd0);
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] y, input logic last,
                        input logic [15:0] mask);
        logic [15:0] d;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_y     = y;
        bus.in_last  = last;
`ifdef GNOT16_CHK_MASK_EN
        bus.in_mask  = mask;
`endif
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
`ifdef GNOT16_CHK_MASK_EN
        d = (y ^ ~a) & mask;
`else
        d = y ^ ~a;
`endif
        if (d != 16'h0 && m_err == 16'h0) begin
            m_idx = m_vec; m_a = a; m_y = y;
        end
        if (m_vec != 16'hFFFF) m_vec = m_vec + 16'd1;
        if (d != 16'h0 && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        for (int i = 0; i < 16; i++) if (d[i]) m_bits = m_bits + 16'd1;
    endtask

    task automatic idle(input logic lst, input logic st);
        bus.in_last = lst;
        start       = st;
        @(posedge clk); #1;
        bus.in_last = 1'b0;
        start       = 1'b0;
    endtask

    task automatic end_run(input string tag);
        exp_t e;
        int   n;
        e.vec = m_vec; e.err = m_err; e.idx = m_idx; e.a = m_a; e.y = m_y; e.bits = m_bits;
        e.pass = (m_err == 16'h0);
        sb.push_back(e);
        n = 0;
        @(negedge clk);
        while (!done && n < 4) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        e = sb.pop_front();
        check({tag, "_vec"}, {16'd0, vec_count}, {16'd0, e.vec});
        check({tag, "_err"}, {16'd0, err_count}, {16'd0, e.err});
        check({tag, "_pass"}, {31'd0, pass}, {31'd0, e.pass});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idx"}, {16'd0, first_err_idx}, {16'd0, e.idx});
        check({tag, "_fa"}, {16'd0, first_err_a}, {16'd0, e.a});
        check({tag, "_fy"}, {16'd0, first_err_y}, {16'd0, e.y});
`ifdef GNOT16_CHK_MASK_EN
        check({tag, "_bits"}, {16'd0, bit_err_count}, {16'd0, e.bits});
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_pass"}, {31'd0, pass}, 32'd0);
        check({tag, "_vec"}, {16'd0, vec_count}, 32'd0);
        check({tag, "_err"}, {16'd0, err_count}, 32'd0);
        check({tag, "_first"}, {first_err_idx, first_err_a ^ first_err_y}, 32'd0);
        check({tag, "_fa"}, {16'd0, first_err_a}, 32'd0);
    endtask

    logic [15:0] va[5];

    initial begin
        va[0] = 16'h0000; va[1] = 16'h0001; va[2] = 16'h5555; va[3] = 16'h01FF; va[4] = 16'hFFFF;
        rst = 1'b1; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_y = '0; bus.in_last = 1'b0;
`ifdef GNOT16_CHK_MASK_EN
        bus.in_mask = '1;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_all_zero("reset");

        // Clean run.
        start_run();
        for (int i = 0; i < 5; i++) beat(va[i], ~va[i], i == 4, 16'hFFFF);
        end_run("clean");
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check("clean_hold_done", {31'd0, done}, 32'd1);
        check("clean_hold_vec", {16'd0, vec_count}, 32'd5);

        // Single corruption on beat 2.
        start_run();
        for (int i = 0; i < 5; i++)
            beat(va[i], (i == 2) ? 16'hAAAB : ~va[i], i == 4, 16'hFFFF);
        end_run("err1");
        check("err1_idx_lit", {16'd0, first_err_idx}, 32'd2);
        check("err1_y_lit", {16'd0, first_err_y}, 32'h0000AAAB);

        // Corruptions on beats 1 and 3; first capture must stick at beat 1.
        start_run();
        for (int i = 0; i < 5; i++)
            beat(va[i], (i == 1 || i == 3) ? (~va[i] ^ 16'h0100) : ~va[i], i == 4, 16'hFFFF);
        end_run("err2");
        check("err2_cnt_lit", {16'd0, err_count}, 32'd2);
        check("err2_idx_lit", {16'd0, first_err_idx}, 32'd1);

        // Valid toggling, stray in_last and ignored start mid-run.
        start_run();
        beat(16'h1234, ~16'h1234, 1'b0, 16'hFFFF);
        idle(1'b1, 1'b0);
        beat(16'hF00F, ~16'hF00F, 1'b0, 16'hFFFF);
        idle(1'b0, 1'b1);
        check("tog_busy", {31'd0, busy}, 32'd1);
        check("tog_vec_mid", {16'd0, vec_count}, {16'd0, m_vec});
        beat(16'h8001, ~16'h8001, 1'b0, 16'hFFFF);
        idle(1'b0, 1'b0);
        check("tog_not_done", {31'd0, done}, 32'd0);
        beat(16'h7FFE, ~16'h7FFE, 1'b1, 16'hFFFF);
        end_run("tog");
        check("tog_vec_lit", {16'd0, vec_count}, 32'd4);

        // Reset mid-run discards everything; next run is clean.
        start_run();
        beat(16'h0F0F, 16'h0000, 1'b0, 16'hFFFF);
        beat(16'h00FF, ~16'h00FF, 1'b0, 16'hFFFF);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("midrst");
        start_run();
        beat(16'hABCD, ~16'hABCD, 1'b0, 16'hFFFF);
        beat(16'h0000, 16'hFFFF, 1'b1, 16'hFFFF);
        end_run("postrst");

`ifdef GNOT16_CHK_MASK_EN
        start_run();
        beat(16'h0000, 16'hFFF0, 1'b0, 16'hFFF0);
        @(negedge clk);
        check("mask_off_err", {16'd0, err_count}, 32'd0);
        beat(16'h0000, 16'hFFF0, 1'b1, 16'hFFFF);
        end_run("mask");
        check("mask_bits_lit", {16'd0, bit_err_count}, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
